// File: rtl/yin_pkg.sv
// Shared YIN definitions: sweep FSM encoding and datapath widths used by the
// scheduler and the difference datapath.
package yin_pkg;

    localparam int unsigned YIN_ACC_WIDTH       = 32;
    localparam int unsigned YIN_TAU_WIDTH       = 6;
    localparam int unsigned YIN_MIN_TAU         = 1;
    localparam int unsigned YIN_MAX_TAU         = 40;
    localparam int unsigned YIN_TH_FRAC_BITS    = 8;
    localparam int unsigned YIN_WATCHDOG_CYCLES = 512;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        EVAL,
        DONE
    } yin_state_e;

endpackage

// File: rtl/yin_tau_scheduler_cmndf_compare.sv
// Cumulative-mean-normalised difference threshold test:
// d*tau*2^TH_W < th*cum_sum, evaluated on full-width unsigned products.
module yin_cmndf_compare
    import yin_pkg::*;
#(
    parameter int unsigned ACC_W = YIN_ACC_WIDTH,
    parameter int unsigned TAU_W = YIN_TAU_WIDTH,
    parameter int unsigned TH_W  = YIN_TH_FRAC_BITS
) (
    input  logic [ACC_W-1:0]       d,
    input  logic [TAU_W-1:0]       tau,
    input  logic [TH_W-1:0]        th,
    input  logic [ACC_W+TAU_W-1:0] cum_sum,
    output logic                   cross_c
);

    localparam int unsigned PW = ACC_W + TAU_W + TH_W;

    logic [PW-1:0] lhs;
    logic [PW-1:0] rhs;

    always_comb begin
        lhs     = (PW'(d) * PW'(tau)) << TH_W;
        rhs     = PW'(th) * PW'(cum_sum);
        cross_c = (lhs < rhs);
    end

endmodule

// File: rtl/yin_tau_scheduler.sv
// YIN lag sweep controller: steps tau through the difference datapath, picks
// the first threshold crossing or falls back to the global minimum.
module yin_tau_scheduler
    import yin_pkg::*;
#(
    parameter int unsigned ACC_WIDTH       = YIN_ACC_WIDTH,
    parameter int unsigned TAU_WIDTH       = YIN_TAU_WIDTH,
    parameter int unsigned MIN_TAU         = YIN_MIN_TAU,
    parameter int unsigned MAX_TAU         = YIN_MAX_TAU,
    parameter int unsigned TH_FRAC_BITS    = YIN_TH_FRAC_BITS,
    parameter int unsigned WATCHDOG_CYCLES = YIN_WATCHDOG_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [TH_FRAC_BITS-1:0] threshold,
    output logic                    busy,
    output logic                    diff_reset,
    output logic [TAU_WIDTH-1:0]    diff_tau,
    input  logic                    diff_ready,
    input  logic [ACC_WIDTH-1:0]    diff_acc,
    output logic                    result_valid,
    output logic [TAU_WIDTH-1:0]    result_tau,
    output logic                    result_found,
    output logic                    error
);

    localparam int unsigned CUM_W = ACC_WIDTH + TAU_WIDTH;
    localparam int unsigned WD_W  = $clog2(WATCHDOG_CYCLES + 1);

    yin_state_e              state_q, state_d;
    logic [TAU_WIDTH-1:0]    tau_q, tau_d;
    logic [CUM_W-1:0]        cum_q, cum_d;
    logic [ACC_WIDTH-1:0]    min_val_q, min_val_d;
    logic [TAU_WIDTH-1:0]    min_tau_q, min_tau_d;
    logic [ACC_WIDTH-1:0]    d_q, d_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [TH_FRAC_BITS-1:0] th_q, th_d;
    logic                    busy_q, busy_d;
    logic                    diff_reset_q, diff_reset_d;
    logic                    result_valid_q, result_valid_d;
    logic [TAU_WIDTH-1:0]    result_tau_q, result_tau_d;
    logic                    result_found_q, result_found_d;
    logic                    error_q, error_d;

    logic [CUM_W-1:0]        cum_new;
    logic                    min_upd;
    logic [TAU_WIDTH-1:0]    min_tau_new;
    logic                    cross_c;

    yin_cmndf_compare #(
        .ACC_W (ACC_WIDTH),
        .TAU_W (TAU_WIDTH),
        .TH_W  (TH_FRAC_BITS)
    ) u_compare (
        .d       (d_q),
        .tau     (tau_q),
        .th      (th_q),
        .cum_sum (cum_new),
        .cross_c (cross_c)
    );

    always_comb begin
        state_d        = state_q;
        tau_d          = tau_q;
        cum_d          = cum_q;
        min_val_d      = min_val_q;
        min_tau_d      = min_tau_q;
        d_d            = d_q;
        wd_d           = wd_q;
        th_d           = th_q;
        busy_d         = busy_q;
        diff_reset_d   = 1'b0;
        result_valid_d = 1'b0;
        result_tau_d   = result_tau_q;
        result_found_d = result_found_q;
        error_d        = 1'b0;

        // Current lag's contribution, visible to the compare and the fallback pick
        cum_new     = cum_q + CUM_W'(d_q);
        min_upd     = (d_q < min_val_q);
        min_tau_new = min_upd ? tau_q : min_tau_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    tau_d        = TAU_WIDTH'(MIN_TAU);
                    cum_d        = '0;
                    min_val_d    = '1;
                    min_tau_d    = TAU_WIDTH'(MIN_TAU);
                    th_d         = threshold;
                    busy_d       = 1'b1;
                    diff_reset_d = 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
                wd_d    = '0;
            end
            RUN: begin
                if (diff_ready) begin
                    state_d = EVAL;
                    d_d     = diff_acc;
                end else if (wd_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            EVAL: begin
                cum_d = cum_new;
                if (min_upd) begin
                    min_val_d = d_q;
                    min_tau_d = tau_q;
                end
                if (cross_c) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_tau_d   = tau_q;
                    result_found_d = 1'b1;
                end else if (tau_q == TAU_WIDTH'(MAX_TAU)) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_tau_d   = min_tau_new;
                    result_found_d = 1'b0;
                end else begin
                    state_d      = LOAD;
                    tau_d        = tau_q + TAU_WIDTH'(1);
                    diff_reset_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            tau_q          <= '0;
            cum_q          <= '0;
            min_val_q      <= '0;
            min_tau_q      <= '0;
            d_q            <= '0;
            wd_q           <= '0;
            th_q           <= '0;
            busy_q         <= 1'b0;
            diff_reset_q   <= 1'b1;
            result_valid_q <= 1'b0;
            result_tau_q   <= '0;
            result_found_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            tau_q          <= tau_d;
            cum_q          <= cum_d;
            min_val_q      <= min_val_d;
            min_tau_q      <= min_tau_d;
            d_q            <= d_d;
            wd_q           <= wd_d;
            th_q           <= th_d;
            busy_q         <= busy_d;
            diff_reset_q   <= diff_reset_d;
            result_valid_q <= result_valid_d;
            result_tau_q   <= result_tau_d;
            result_found_q <= result_found_d;
            error_q        <= error_d;
        end
    end

    assign busy         = busy_q;
    assign diff_reset   = diff_reset_q;
    assign diff_tau     = tau_q;
    assign result_valid = result_valid_q;
    assign result_tau   = result_tau_q;
    assign result_found = result_found_q;
    assign error        = error_q;

endmodule

// File: tb/tb_yin_tau_scheduler.sv
// Directed bench for yin_tau_scheduler with a behavioural difference datapath
// whose ready latency and per-lag d(tau) table are set by each scenario.
module tb_yin_tau_scheduler;
    import yin_pkg::*;

    localparam int unsigned AW = YIN_ACC_WIDTH;
    localparam int unsigned TW = YIN_TAU_WIDTH;
    localparam int unsigned HW = YIN_TH_FRAC_BITS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [HW-1:0] threshold = '0;
    logic          busy;
    logic          diff_reset;
    logic [TW-1:0] diff_tau;
    logic          diff_ready;
    logic [AW-1:0] diff_acc;
    logic          result_valid;
    logic [TW-1:0] result_tau;
    logic          result_found;
    logic          error;

    int checks = 0;
    int passes = 0;

    logic [AW-1:0] d_tab [0:63];
    int            lat = 3;
    bit            ready_en = 1'b1;
    int            cnt = 0;
    int            load_count = 0;

    always #5 clk = ~clk;

    yin_tau_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .threshold    (threshold),
        .busy         (busy),
        .diff_reset   (diff_reset),
        .diff_tau     (diff_tau),
        .diff_ready   (diff_ready),
        .diff_acc     (diff_acc),
        .result_valid (result_valid),
        .result_tau   (result_tau),
        .result_found (result_found),
        .error        (error)
    );

    // Datapath model: ready on the lat-th cycle after diff_reset drops
    always @(posedge clk) begin
        if (diff_reset) cnt <= 0;
        else if (cnt < lat) cnt <= cnt + 1;
        if (diff_reset && busy) load_count <= load_count + 1;
    end
    assign diff_ready = ready_en && !diff_reset && (cnt == lat - 1);
    assign diff_acc   = d_tab[diff_tau];

    task automatic fill_tab(input logic [AW-1:0] v);
        for (int i = 0; i < 64; i++) d_tab[i] = v;
    endtask

    // Cycle 0 = start cycle; returns the cycle of result_valid or error
    task automatic run_sweep(input logic [HW-1:0] th, input int bound, input int pulse_at,
                             output int cyc, output bit got_valid, output bit got_err);
        got_valid = 1'b0;
        got_err   = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        threshold = th;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < bound) begin
            start = (cyc == pulse_at);
            if (cyc == pulse_at) threshold = '0;
            if (result_valid) begin got_valid = 1'b1; break; end
            if (error) begin got_err = 1'b1; break; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passes++;
        checks++; if (diff_reset !== 1'b1) $display("FAIL rst_diff_reset got %b exp 1", diff_reset); else passes++;
        checks++; if (diff_tau !== '0) $display("FAIL rst_diff_tau got %0d exp 0", diff_tau); else passes++;
        checks++; if (result_valid !== 1'b0) $display("FAIL rst_result_valid got %b exp 0", result_valid); else passes++;
        checks++; if (result_tau !== '0) $display("FAIL rst_result_tau got %0d exp 0", result_tau); else passes++;
        checks++; if (result_found !== 1'b0) $display("FAIL rst_result_found got %b exp 0", result_found); else passes++;
        checks++; if (error !== 1'b0) $display("FAIL rst_error got %b exp 0", error); else passes++;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (diff_reset !== 1'b0) $display("FAIL rst_diff_reset_drop got %b exp 0", diff_reset); else passes++;
    endtask

    task automatic test_no_crossing();
        int cyc; bit v; bit e;
        lat = 256;
        fill_tab(AW'(1000));
        run_sweep(8'h80, 20000, 0, cyc, v, e);
        checks++; if (!(v === 1'b1 && e === 1'b0)) $display("FAIL nocross_valid got valid=%b err=%b exp 1/0", v, e); else passes++;
        checks++; if (cyc !== 40 * 258 + 1) $display("FAIL nocross_latency got %0d exp %0d", cyc, 40 * 258 + 1); else passes++;
        checks++; if (result_found !== 1'b0) $display("FAIL nocross_found got %b exp 0", result_found); else passes++;
        checks++; if (result_tau !== TW'(1)) $display("FAIL nocross_tau got %0d exp 1", result_tau); else passes++;
        @(posedge clk); #1;
        checks++; if (result_valid !== 1'b0) $display("FAIL nocross_valid_pulse got %b exp 0", result_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL nocross_busy_end got %b exp 0", busy); else passes++;
        checks++; if (result_tau !== TW'(1)) $display("FAIL nocross_tau_hold got %0d exp 1", result_tau); else passes++;
    endtask

    task automatic set_cross_tab();
        fill_tab(AW'(1000));
        d_tab[5] = AW'(100);
    endtask

    task automatic set_tie_tab();
        fill_tab(AW'(500));
        d_tab[7] = AW'(200);
        d_tab[9] = AW'(200);
    endtask

    task automatic test_crossing();
        int cyc; bit v; bit e; int loads0;
        lat = 4;
        set_cross_tab();
        loads0 = load_count;
        run_sweep(8'h40, 2000, 0, cyc, v, e);
        checks++; if (!(v === 1'b1 && cyc == 31)) $display("FAIL cross_latency got valid=%b cyc=%0d exp 1/31", v, cyc); else passes++;
        checks++; if (result_found !== 1'b1) $display("FAIL cross_found got %b exp 1", result_found); else passes++;
        checks++; if (result_tau !== TW'(5)) $display("FAIL cross_tau got %0d exp 5", result_tau); else passes++;
        checks++; if (load_count - loads0 != 5) $display("FAIL cross_loads got %0d exp 5", load_count - loads0); else passes++;
    endtask

    task automatic test_min_tie();
        int cyc; bit v; bit e;
        lat = 3;
        set_tie_tab();
        run_sweep(8'h00, 2000, 0, cyc, v, e);
        checks++; if (!(v === 1'b1 && cyc == 201)) $display("FAIL tie_latency got valid=%b cyc=%0d exp 1/201", v, cyc); else passes++;
        checks++; if (result_tau !== TW'(7)) $display("FAIL tie_tau got %0d exp 7", result_tau); else passes++;
        checks++; if (result_found !== 1'b0) $display("FAIL tie_found got %b exp 0", result_found); else passes++;
    endtask

    task automatic test_watchdog();
        int cyc; bit v; bit e;
        ready_en = 1'b0;
        run_sweep(8'h80, 2000, 0, cyc, v, e);
        checks++; if (!(e === 1'b1 && v === 1'b0)) $display("FAIL wd_error got err=%b valid=%b exp 1/0", e, v); else passes++;
        checks++; if (cyc !== 514) $display("FAIL wd_latency got %0d exp 514", cyc); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL wd_busy got %b exp 0", busy); else passes++;
        @(posedge clk); #1;
        checks++; if (error !== 1'b0 || result_valid !== 1'b0) $display("FAIL wd_pulse got err=%b valid=%b exp 0/0", error, result_valid); else passes++;
        ready_en = 1'b1;
    endtask

    task automatic test_reset_mid_sweep();
        int n; bit seen;
        lat = 3;
        fill_tab(AW'(1000));
        @(posedge clk); #1;
        start = 1'b1;
        threshold = 8'h80;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(busy && !diff_reset && diff_tau == TW'(3)) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n >= 200) $display("FAIL midrst_reach_tau3 got timeout exp tau=3 in RUN"); else passes++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", busy); else passes++;
        checks++; if (diff_reset !== 1'b1) $display("FAIL midrst_diff_reset got %b exp 1", diff_reset); else passes++;
        checks++; if (diff_tau !== '0) $display("FAIL midrst_diff_tau got %0d exp 0", diff_tau); else passes++;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (result_valid || error || busy || diff_reset) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL midrst_quiet got activity=%b exp 0", seen); else passes++;
    endtask

    task automatic test_back_to_back();
        int cyc; bit v; bit e;
        lat = 4;
        set_cross_tab();
        run_sweep(8'h40, 2000, 7, cyc, v, e);
        checks++; if (!(v === 1'b1 && cyc == 31)) $display("FAIL ignstart_latency got valid=%b cyc=%0d exp 1/31", v, cyc); else passes++;
        checks++; if (result_tau !== TW'(5) || result_found !== 1'b1) $display("FAIL ignstart_result got tau=%0d found=%b exp 5/1", result_tau, result_found); else passes++;
        lat = 3;
        set_tie_tab();
        run_sweep(8'h00, 2000, 0, cyc, v, e);
        checks++; if (!(v === 1'b1 && cyc == 201)) $display("FAIL b2b_latency got valid=%b cyc=%0d exp 1/201", v, cyc); else passes++;
        checks++; if (result_tau !== TW'(7) || result_found !== 1'b0) $display("FAIL b2b_result got tau=%0d found=%b exp 7/0", result_tau, result_found); else passes++;
    endtask

    initial begin
        fill_tab(AW'(1000));
        test_reset();
        test_no_crossing();
        test_crossing();
        test_min_tie();
        test_watchdog();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/yin_tau_scheduler.md
YIN_TAU_SCHEDULER -- requirements
Module: yin_tau_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
  ACC_WIDTH, 32, width of difference-accumulator result
  TAU_WIDTH, 6, width of tau values
  MIN_TAU, 1, first lag evaluated
  MAX_TAU, 40, last lag evaluated
  TH_FRAC_BITS, 8, fractional bits of threshold (unsigned Q0.TH_FRAC_BITS)
  WATCHDOG_CYCLES, 512, max cycles allowed per lag in RUN
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock; all logic on rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  single-cycle request to begin a lag sweep
  threshold  in  TH_FRAC_BITS  normalized-difference threshold, sampled on accepted start
  busy  out  1  high from accepted start until result_valid or error
  diff_reset  out  1  synchronous reset to difference datapath
  diff_tau  out  TAU_WIDTH  lag presented to difference datapath
  diff_ready  in  1  difference datapath finished current lag
  diff_acc  in  ACC_WIDTH  difference sum d(tau), valid while diff_ready high
  result_valid  out  1  one-cycle pulse, sweep complete
  result_tau  out  TAU_WIDTH  selected lag
  result_found  out  1  1 = threshold crossing, 0 = fallback to global minimum
  error  out  1  one-cycle pulse, watchdog expiry; sweep aborted

Function
REQ-003 FSM states SHALL be IDLE, LOAD, RUN, EVAL, DONE.
REQ-004 IDLE: start=1 -> LOAD; tau<=MIN_TAU, cum_sum<=0, min_val<=all-ones, min_tau<=MIN_TAU, th_reg<=threshold, busy<=1.
REQ-005 start while busy SHALL be ignored.
REQ-006 LOAD: diff_reset=1 for exactly one cycle with diff_tau=tau; next state RUN; watchdog counter cleared.
REQ-007 RUN: diff_reset=0, diff_tau held; diff_ready=1 -> EVAL with d_reg<=diff_acc; watchdog counter increments each cycle.
REQ-008 Watchdog reaching WATCHDOG_CYCLES in RUN SHALL pulse error, deassert busy, return IDLE, no result_valid.
REQ-009 EVAL (one cycle): cum_sum<=cum_sum+d_reg, width ACC_WIDTH+TAU_WIDTH, no overflow possible.
REQ-010 Crossing test, unsigned, using the updated cum_sum: d_reg*tau*2^TH_FRAC_BITS < th_reg*cum_sum; both products ACC_WIDTH+TAU_WIDTH+TH_FRAC_BITS bits; strict less-than.
REQ-011 cum_sum=0 SHALL never cross (0<0 false).
REQ-012 Minimum tracking: d_reg < min_val -> min_val<=d_reg, min_tau<=tau; ties keep smaller tau.
REQ-013 EVAL next state: crossing -> DONE with result_tau=tau, result_found=1; else tau=MAX_TAU -> DONE with result_tau=min_tau (including the current lag's update), result_found=0; else tau<=tau+1, -> LOAD.
REQ-014 DONE: result_valid=1 for one cycle, busy<=0, -> IDLE; result_tau/result_found held until next accepted start.
REQ-015 Latency per lag SHALL be LOAD(1)+RUN(n)+EVAL(1) cycles, where n = cycles until diff_ready; no extra bubbles.
REQ-016 diff_ready outside RUN SHALL be ignored.
REQ-017 MIN_TAU=MAX_TAU SHALL yield exactly one lag evaluation.

Reset
REQ-018 reset SHALL force IDLE from any state, including mid-sweep, with no result_valid or error pulse.
REQ-019 Reset values: busy=0, diff_reset=1, diff_tau=0, result_valid=0, result_tau=0, result_found=0, error=0; internal tau, cum_sum, min_val, min_tau, d_reg, watchdog, th_reg cleared.
REQ-020 diff_reset SHALL drop to 0 in the first IDLE cycle after reset and stay 0 except in LOAD.

Structure
REQ-021 FSM state encoding, ACC_WIDTH, TAU_WIDTH, MAX_TAU, TH_FRAC_BITS SHALL reside in a shared YIN package used with the difference datapath.
REQ-022 One sub-module, yin_cmndf_compare, SHALL hold the REQ-010 multiply/compare logic, purely combinational.

Verification
REQ-023 Behavioural datapath model with ready after 256 cycles, d(tau)=1000 for all tau, threshold=0x80 -> no crossing (d*tau*256 vs 128*1000*tau), result_found=0, result_tau=1, result_valid at cycle 40*258+1 after start.
REQ-024 d(1..4)=1000, d(5)=100, threshold=0x40 -> crossing at tau=5 (100*5*256=128000 < 64*4100=262400), result_tau=5, result_found=1, no LOAD for tau 6.
REQ-025 d(tau)=500 except d(7)=d(9)=200, threshold=0 -> result_tau=7, result_found=0 (tie keeps smaller).
REQ-026 Datapath never asserts ready -> error pulse 512 cycles after RUN entry for tau=1, busy=0, no result_valid.
REQ-027 reset asserted in RUN at tau=3 -> next cycle IDLE, busy=0, diff_reset=1; start pulse during busy -> ignored, sweep continues unchanged.
